// File: rtl/flatten_stream_mc_pkg.sv
// Shared types and index mapping for the multi-channel flattener.
package flatten_pkg;

    typedef enum logic {
        SKIP = 1'b0,
        FILL = 1'b1
    } cap_state_e;

    // Position of pixel p of channel c inside the flattened output vector.
    function automatic int flat_index(
        input int c,
        input int p,
        input int image_size,
        input int num_channels,
        input int channel_major
    );
        if (channel_major != 0) begin
            return c * image_size + p;
        end else begin
            return p * num_channels + c;
        end
    endfunction

endpackage

// File: rtl/flatten_stream_mc_if.sv
// Pixel-stream input and flattened-image output handshakes of the flattener.
interface flatten_stream_mc_if #(
    parameter int BitSize     = 4,
    parameter int ImageSize   = 9,
    parameter int NumChannels = 2
);
    logic                                            in_valid;
    logic [NumChannels-1:0][BitSize-1:0]             in_data;
    logic                                            in_ready;
    logic [NumChannels*ImageSize-1:0][BitSize-1:0]   out_data;
    logic                                            out_valid;
    logic                                            out_ready;
    logic                                            out_done;

    // Producer of pixels and consumer of images.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_data, out_valid, out_done
    );

    // The flattener itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_data, out_valid, out_done
    );
endinterface

// File: rtl/flatten_stream_mc_bank.sv
// One image bank: NumChannels x ImageSize pixel registers written one beat at a time.
module flatten_bank #(
    parameter int BitSize     = 4,
    parameter int ImageSize   = 9,
    parameter int NumChannels = 2,
    parameter int PixW        = 4
) (
    input  logic                                            clk,
    input  logic                                            res_n,
    input  logic                                            we,
    input  logic [PixW-1:0]                                 idx,
    input  logic [NumChannels-1:0][BitSize-1:0]             wdata,
    output logic [NumChannels-1:0][ImageSize-1:0][BitSize-1:0] mem
);

    // Store every channel's pixel of the current beat at the same pixel index.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            mem <= '0;
        end else if (we) begin
            for (int c = 0; c < NumChannels; c++) begin
                mem[c][idx] <= wdata[c];
            end
        end
    end

endmodule

// File: rtl/flatten_stream_mc.sv
// Ping-pong flattener: skips pipeline-fill beats, captures images, hands them out whole.
module flatten_stream_mc
    import flatten_pkg::*;
#(
    parameter int BitSize         = 4,
    parameter int ImageSize       = 9,
    parameter int NumChannels     = 2,
    parameter int Delay           = 3,
    parameter int DelayEveryImage = 0,
    parameter int ChannelMajor    = 1
) (
    input  logic               clk,
    input  logic               res_n,
    flatten_stream_mc_if.slave bus
);

    localparam int PixW  = (ImageSize > 1) ? $clog2(ImageSize) : 1;
    localparam int SkipW = (Delay > 0) ? $clog2(Delay + 1) : 1;
    localparam cap_state_e StartState = (Delay == 0) ? FILL : SKIP;
    localparam cap_state_e AfterImage = ((DelayEveryImage != 0) && (Delay != 0)) ? SKIP : FILL;
    localparam logic [PixW-1:0]  LastPix  = PixW'(ImageSize - 1);
    localparam logic [SkipW-1:0] LastSkip = SkipW'(Delay - 1);

    cap_state_e       state_r, state_s;
    logic [PixW-1:0]  pix_r, pix_s;
    logic [SkipW-1:0] skip_r, skip_s;
    logic             wr_sel_r, wr_sel_s;
    logic             rd_sel_r, rd_sel_s;
    logic [1:0]       full_r, full_s;
    logic             done_r, done_s;
    logic             we_s;
    logic             accept_s;
    logic             pop_s;

    logic [NumChannels-1:0][ImageSize-1:0][BitSize-1:0] mem0_s;
    logic [NumChannels-1:0][ImageSize-1:0][BitSize-1:0] mem1_s;

    assign accept_s = bus.in_valid && !full_r[wr_sel_r];
    assign pop_s    = full_r[rd_sel_r] && bus.out_ready;

    // Capture FSM, counters, bank pointers and full flags: next-state logic.
    always_comb begin
        state_s  = state_r;
        pix_s    = pix_r;
        skip_s   = skip_r;
        wr_sel_s = wr_sel_r;
        rd_sel_s = rd_sel_r;
        full_s   = full_r;
        done_s   = 1'b0;
        we_s     = 1'b0;
        case (state_r)
            SKIP: begin
                if (accept_s) begin
                    if (skip_r == LastSkip) begin
                        state_s = FILL;
                        skip_s  = '0;
                    end else begin
                        skip_s = skip_r + SkipW'(1);
                    end
                end else begin
                    skip_s = skip_r;
                end
            end
            FILL: begin
                if (accept_s) begin
                    we_s = 1'b1;
                    if (pix_r == LastPix) begin
                        pix_s            = '0;
                        full_s[wr_sel_r] = 1'b1;
                        wr_sel_s         = ~wr_sel_r;
                        done_s           = 1'b1;
                        state_s          = AfterImage;
                    end else begin
                        pix_s = pix_r + PixW'(1);
                    end
                end else begin
                    pix_s = pix_r;
                end
            end
            default: begin
                state_s = StartState;
            end
        endcase
        // A pop always frees the read bank, which is never the bank just completed.
        if (pop_s) begin
            full_s[rd_sel_r] = 1'b0;
            rd_sel_s         = ~rd_sel_r;
        end else begin
            rd_sel_s = rd_sel_r;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_r  <= StartState;
            pix_r    <= '0;
            skip_r   <= '0;
            wr_sel_r <= 1'b0;
            rd_sel_r <= 1'b0;
            full_r   <= 2'b00;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            pix_r    <= pix_s;
            skip_r   <= skip_s;
            wr_sel_r <= wr_sel_s;
            rd_sel_r <= rd_sel_s;
            full_r   <= full_s;
            done_r   <= done_s;
        end
    end

    flatten_bank #(
        .BitSize(BitSize), .ImageSize(ImageSize), .NumChannels(NumChannels), .PixW(PixW)
    ) u_bank0 (
        .clk(clk), .res_n(res_n), .we(we_s && !wr_sel_r), .idx(pix_r),
        .wdata(bus.in_data), .mem(mem0_s)
    );

    flatten_bank #(
        .BitSize(BitSize), .ImageSize(ImageSize), .NumChannels(NumChannels), .PixW(PixW)
    ) u_bank1 (
        .clk(clk), .res_n(res_n), .we(we_s && wr_sel_r), .idx(pix_r),
        .wdata(bus.in_data), .mem(mem1_s)
    );

    assign bus.in_ready  = !full_r[wr_sel_r];
    assign bus.out_valid = full_r[rd_sel_r];
    assign bus.out_done  = done_r;

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        for (genvar p = 0; p < ImageSize; p++) begin : g_px
            localparam int Fi = flat_index(c, p, ImageSize, NumChannels, ChannelMajor);
            assign bus.out_data[Fi] = rd_sel_r ? mem1_s[c][p] : mem0_s[c][p];
        end
    end

endmodule
